// File: rtl/dfi_rddata_fifo.sv
// DFI read-data return buffer: compacts valid phase words into a FIFO drained over valid/ready,
// and tracks outstanding read beats with sticky protocol error flags.
module dfi_rddata_fifo #(
  parameter int C_PHASES          = 2,
  parameter int C_PHASE_WIDTH     = 32,
  parameter int C_FIFO_DEPTH      = 16,
  parameter int C_MAX_OUTSTANDING = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [C_PHASES-1:0]                      dfi_rddata_en,
  input  logic [C_PHASES-1:0]                      dfi_rddata_valid,
  input  logic [C_PHASES*C_PHASE_WIDTH-1:0]        dfi_rddata,
  output logic [C_PHASE_WIDTH-1:0]                 rd_data,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0]        fifo_free,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0]   outstanding,
  input  logic                                     err_clr,
  output logic                                     err_overflow,
  output logic                                     err_unexpected,
  output logic                                     err_credit
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(C_FIFO_DEPTH + 1);
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(C_PHASES + 1);
  localparam int SW = OW + CW + 1;

  function automatic logic [CW-1:0] popcnt(input logic [C_PHASES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < C_PHASES; i++) begin
      if (v[i]) popcnt = popcnt + CW'(1);
    end
  endfunction

  logic [C_PHASE_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]            npush, nen, accepted, slot;
  logic [FW:0]              room;
  logic                     pop, overflow_set;
  logic [FW-1:0]            free_next;
  logic [C_PHASES-1:0]      acc;
  logic [AW-1:0]            waddr [C_PHASES];
  logic [C_PHASE_WIDTH-1:0] first_word, rd_data_next;
  logic                     have_first;
  logic [SW-1:0]            credit, diff;
  logic [OW-1:0]            out_next;
  logic                     unexp_set, credit_set;

  // Room counts the slot freed by a same-cycle pop; excess words fall off the highest phases.
  always_comb begin
    npush        = popcnt(dfi_rddata_valid);
    nen          = popcnt(dfi_rddata_en);
    pop          = rd_valid & rd_ready;
    room         = (FW+1)'(fifo_free) + (FW+1)'(pop);
    overflow_set = 1'b0;
    accepted     = npush;
    if ((FW+1)'(npush) > room) begin
      accepted     = CW'(room);
      overflow_set = 1'b1;
    end

    slot       = '0;
    first_word = '0;
    have_first = 1'b0;
    for (int p = 0; p < C_PHASES; p++) begin
      acc[p]   = 1'b0;
      waddr[p] = wr_ptr[AW-1:0] + AW'(slot);
      if (dfi_rddata_valid[p]) begin
        acc[p] = (slot < accepted);
        if (!have_first) begin
          first_word = dfi_rddata[p*C_PHASE_WIDTH +: C_PHASE_WIDTH];
          have_first = 1'b1;
        end
        slot = slot + CW'(1);
      end
    end

    free_next   = fifo_free - FW'(accepted) + FW'(pop);
    rd_ptr_next = rd_ptr + PW'(pop);

    // The registered head comes from memory if a word survives the pop, else bypasses the first new word.
    rd_data_next = rd_data;
    if (room < (FW+1)'(C_FIFO_DEPTH))
      rd_data_next = mem[rd_ptr_next[AW-1:0]];
    else if (accepted != '0)
      rd_data_next = first_word;
  end

  always_comb begin
    credit     = SW'(outstanding) + SW'(nen);
    diff       = '0;
    out_next   = outstanding;
    unexp_set  = 1'b0;
    credit_set = 1'b0;
    if (SW'(npush) > credit) begin
      out_next  = '0;
      unexp_set = 1'b1;
    end else begin
      diff = credit - SW'(npush);
      if (diff > SW'(C_MAX_OUTSTANDING)) begin
        out_next   = OW'(C_MAX_OUTSTANDING);
        credit_set = 1'b1;
      end else begin
        out_next = OW'(diff);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < C_PHASES; p++) begin
      if (acc[p]) mem[waddr[p]] <= dfi_rddata[p*C_PHASE_WIDTH +: C_PHASE_WIDTH];
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_free      <= FW'(C_FIFO_DEPTH);
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      outstanding    <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
      err_credit     <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr + PW'(accepted);
      rd_ptr         <= rd_ptr_next;
      fifo_free      <= free_next;
      rd_valid       <= (free_next != FW'(C_FIFO_DEPTH));
      rd_data        <= rd_data_next;
      outstanding    <= out_next;
      err_overflow   <= overflow_set | (err_overflow & ~err_clr);
      err_unexpected <= unexp_set | (err_unexpected & ~err_clr);
      err_credit     <= credit_set | (err_credit & ~err_clr);
    end
  end

endmodule
